store_queue_param: RTL and testbench
====================================

// Module: store_queue_param
// PURPOSE
// Parametrised in-order store queue between dual-issue dispatch and the data-memory write port.
// Allocates up to two stores per cycle and accepts address results from AGUs by SQ index.
// Marks stores committed in program order on ROB retirement and drains committed stores to memory over a valid/ready port.
// Supports pipeline flush of all uncommitted entries.
// PARAMETERS
// DEPTH   8   entries; power of two, >=4; pointer width PW=$clog2(DEPTH)
// ADDR_W  32  store address width
// DATA_W  32  store data width
// ROB_W   6   ROB index width
// PORTS
// clk            in   1       clock, rising edge
// reset          in   1       asynchronous, active-high
// disp_valid_1/2 in   1       dispatch request, slot 1 older than slot 2
// disp_rob_1/2   in   ROB_W   ROB index of dispatched store
// disp_data_1/2  in   DATA_W  store data
// alloc_idx_1/2  out  PW      SQ index granted to slot 1/2; valid in the same cycle as the request
// disp_accept_1/2 out 1       slot accepted this cycle (combinational)
// agu_valid_1/2  in   1       address result valid
// agu_idx_1/2    in   PW      SQ index being updated
// agu_addr_1/2   in   ADDR_W  computed address
// commit_valid   in   1       ROB retires the oldest uncommitted store
// commit_ready   out  1       entry at commit pointer has its address (state READY)
// commit_rob     out  ROB_W   ROB index of entry at commit pointer
// mem_req_valid  out  1       head entry is COMMITTED
// mem_req_addr   out  ADDR_W  head address
// mem_req_data   out  DATA_W  head data
// mem_req_ready  in   1       memory accepts request
// flush          in   1       discard all uncommitted entries
// count          out  PW+1    occupied entries (registered)
// sq_full        out  1       count==DEPTH (registered)
// sq_empty       out  1       count==0 (registered)
// BEHAVIOUR
// - Per-entry state: FREE -> WAIT_ADDR (dispatch) -> READY (agu update) -> COMMITTED (commit) -> FREE (drain).
// - Pointers: head (drain), cptr (commit), tail (alloc), each PW bits, wrapping modulo DEPTH.
// - Ordering invariant: head <= cptr <= tail in queue order.
// - Reset: all entries FREE; head=cptr=tail=0; count=0; sq_empty=1; sq_full=0; mem_req_valid=0; commit_ready=0.
// - Reset asserted mid-operation discards everything, including COMMITTED entries.
// - free = DEPTH-count, using the registered count. No same-cycle bypass: a pop does not free space for a dispatch in the same cycle.
// - disp_accept_1 = disp_valid_1 && free>=1.
// - disp_accept_2 = disp_valid_2 && free >= (disp_accept_1 ? 2 : 1).
// - alloc_idx_1=tail. alloc_idx_2 = tail+disp_accept_1.
// - tail advances by the number of accepted slots.
// - AGU update: if entry[agu_idx] is WAIT_ADDR, store the address and move the entry to READY next cycle. Ignore the update in any other state.
// - Both AGU ports may update different entries in one cycle. If both name the same index, port 1 wins.
// - Commit: commit_valid && commit_ready -> entry[cptr] becomes COMMITTED; cptr+1.
// - commit_valid while !commit_ready is a protocol error: ignore it, no state change.
// - Drain: mem_req_* driven combinationally from entry[head]. On mem_req_valid && mem_req_ready, the entry becomes FREE and head advances by 1. Hold the request until accepted.
// - count_next = count + accepts - pop - flushed.
// - Flush: every entry in [cptr, tail) becomes FREE; tail<=cptr; count<=cptr-head (modulo distance, plus any commit-free pop adjustment).
// - Flush has priority over dispatch, AGU update and commit in that cycle; disp_accept_* are 0 during flush.
// - A drain pop in the same cycle still completes.
// - A commit in the flush cycle is ignored, so the ROB must not commit and flush together.
// - Wrap-around: modulo arithmetic on all pointers. count distinguishes full (DEPTH) from empty (0) when head==tail.
// TESTING
// - Reset, then dispatch 2 stores (rob 3,4) -> alloc_idx 0,1; count=2 next cycle; sq_empty=0.
// - Fill with DEPTH=8 via 4 dual dispatches -> sq_full=1. Further disp_valid_1/2 -> disp_accept_1/2=0.
// - With count=7, dispatch both slots -> only slot 1 accepted (alloc 7), slot 2 rejected; sq_full=1 next cycle.
// - AGU writes idx1 before idx0. commit_ready stays 0 until idx0 is READY. Then commit twice -> mem_req_valid with head address/data. With mem_req_ready held low for 3 cycles, outputs are stable; after ready, head advances.
// - Three entries: 1 COMMITTED, 2 READY; flush -> count=1, tail=cptr. Committed store still drains. A new dispatch gets alloc_idx = old cptr.
// - Run 20 dispatch/commit/drain cycles across pointer wrap (DEPTH=8) -> addresses/data drain in dispatch order; count returns to 0; sq_empty=1.

Source files
------------

// File: rtl/store_queue_param.sv
// store_queue_param -- in-order store queue sitting between dual-issue
// dispatch and the data-memory write port.
//
// Entry lifecycle: FREE -> WAIT_ADDR -> READY -> COMMITTED -> FREE.
//   dispatch  : up to two stores per cycle are allocated at tail (slot 1 is older)
//   agu       : two address-result ports, each addressed by SQ index
//   commit    : the ROB retires stores in program order through cptr
//   drain     : the head entry is offered to memory over valid/ready
//   flush     : drops every uncommitted entry and pulls tail back to cptr
//
// Ports
//   clk, reset                      clock (rising edge); async active-high reset
//   disp_valid/rob/data_1/2         dispatch requests
//   alloc_idx_1/2, disp_accept_1/2  granted index and accept, same cycle
//   agu_valid/idx/addr_1/2          address results
//   commit_valid                    retire the oldest uncommitted store
//   commit_ready, commit_rob        entry at cptr is READY, and its ROB index
//   mem_req_valid/addr/data/ready   drain port, driven from the head entry
//   flush                           discard uncommitted entries
//   count, sq_full, sq_empty        registered occupancy

package sq_pkg;
  localparam logic [1:0] ST_FREE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ADDR = 2'd1;
  localparam logic [1:0] ST_READY     = 2'd2;
  localparam logic [1:0] ST_COMMITTED = 2'd3;
endpackage

// One queue slot: holds the state, ROB index, address and data of one store.
module sq_entry
  import sq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic [ROB_W-1:0]  alloc_rob,
  input  logic [DATA_W-1:0] alloc_data,
  input  logic              agu_wr,
  input  logic [ADDR_W-1:0] agu_addr,
  input  logic              commit,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        state,
  output logic [ROB_W-1:0]  rob,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FREE;
      rob   <= '0;
      addr  <= '0;
      data  <= '0;
    end else if (pop) begin
      // pop is only raised for a COMMITTED head, which flush never touches,
      // so a drain in the flush cycle still completes
      state <= ST_FREE;
    end else if (flush) begin
      if (state == ST_WAIT_ADDR || state == ST_READY) state <= ST_FREE;
    end else if (alloc) begin
      state <= ST_WAIT_ADDR;
      rob   <= alloc_rob;
      data  <= alloc_data;
    end else if (agu_wr && state == ST_WAIT_ADDR) begin
      addr  <= agu_addr;
      state <= ST_READY;
    end else if (commit && state == ST_READY) begin
      state <= ST_COMMITTED;
    end
  end
endmodule

module store_queue_param
  import sq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_valid_1,
  input  logic              disp_valid_2,
  input  logic [ROB_W-1:0]  disp_rob_1,
  input  logic [ROB_W-1:0]  disp_rob_2,
  input  logic [DATA_W-1:0] disp_data_1,
  input  logic [DATA_W-1:0] disp_data_2,
  output logic [PW-1:0]     alloc_idx_1,
  output logic [PW-1:0]     alloc_idx_2,
  output logic              disp_accept_1,
  output logic              disp_accept_2,
  input  logic              agu_valid_1,
  input  logic              agu_valid_2,
  input  logic [PW-1:0]     agu_idx_1,
  input  logic [PW-1:0]     agu_idx_2,
  input  logic [ADDR_W-1:0] agu_addr_1,
  input  logic [ADDR_W-1:0] agu_addr_2,
  input  logic              commit_valid,
  output logic              commit_ready,
  output logic [ROB_W-1:0]  commit_rob,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  input  logic              flush,
  output logic [PW:0]       count,
  output logic              sq_full,
  output logic              sq_empty
);
  logic [PW-1:0] head, cptr, tail;
  logic [PW:0]   free, n_committed, count_next;
  logic          do_commit, pop;

  logic [1:0]                    ent_state [DEPTH];
  logic [DEPTH-1:0][ROB_W-1:0]  ent_rob;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  // Space comes from the registered count only: a pop this cycle does not
  // make room for a dispatch this cycle.
  assign free          = (PW+1)'(DEPTH) - count;
  assign disp_accept_1 = disp_valid_1 && !flush && (free >= (PW+1)'(1));
  assign disp_accept_2 = disp_valid_2 && !flush &&
                         (free >= (disp_accept_1 ? (PW+1)'(2) : (PW+1)'(1)));
  assign alloc_idx_1   = tail;
  assign alloc_idx_2   = tail + PW'(disp_accept_1);

  assign commit_ready  = (ent_state[cptr] == ST_READY);
  assign commit_rob    = ent_rob[cptr];
  // commit without commit_ready, or during flush, is dropped
  assign do_commit     = commit_valid && commit_ready && !flush;

  assign mem_req_valid = (ent_state[head] == ST_COMMITTED);
  assign mem_req_addr  = ent_addr[head];
  assign mem_req_data  = ent_data[head];
  assign pop           = mem_req_valid && mem_req_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic              a1_hit, a2_hit, alloc, agu1_hit, agu2_hit;
    logic [ROB_W-1:0]  rob_in;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] addr_in;

    assign a1_hit   = disp_accept_1 && (alloc_idx_1 == PW'(i));
    assign a2_hit   = disp_accept_2 && (alloc_idx_2 == PW'(i));
    assign alloc    = a1_hit || a2_hit;
    assign rob_in   = a1_hit ? disp_rob_1  : disp_rob_2;
    assign data_in  = a1_hit ? disp_data_1 : disp_data_2;
    assign agu1_hit = agu_valid_1 && (agu_idx_1 == PW'(i));
    assign agu2_hit = agu_valid_2 && (agu_idx_2 == PW'(i));
    // port 1 wins when both AGUs name the same entry
    assign addr_in  = agu1_hit ? agu_addr_1 : agu_addr_2;

    sq_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_ent (
      .clk        (clk),
      .reset      (reset),
      .alloc      (alloc),
      .alloc_rob  (rob_in),
      .alloc_data (data_in),
      .agu_wr     (!flush && (agu1_hit || agu2_hit)),
      .agu_addr   (addr_in),
      .commit     (do_commit && (cptr == PW'(i))),
      .pop        (pop && (head == PW'(i))),
      .flush      (flush),
      .state      (ent_state[i]),
      .rob        (ent_rob[i]),
      .addr       (ent_addr[i]),
      .data       (ent_data[i])
    );
  end

  // After a flush only COMMITTED entries survive. Counting them directly
  // avoids the head==cptr ambiguity of a pointer distance when all DEPTH
  // entries are committed.
  always_comb begin
    n_committed = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_state[i] == ST_COMMITTED) n_committed = n_committed + (PW+1)'(1);
  end

  always_comb begin
    count_next = count;
    if (flush)
      count_next = n_committed - (PW+1)'(pop);
    else
      count_next = count + (PW+1)'(disp_accept_1) + (PW+1)'(disp_accept_2)
                   - (PW+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      cptr     <= '0;
      tail     <= '0;
      count    <= '0;
      sq_full  <= 1'b0;
      sq_empty <= 1'b1;
    end else begin
      head     <= head + PW'(pop);
      cptr     <= cptr + PW'(do_commit);
      tail     <= flush ? cptr
                        : tail + PW'(disp_accept_1) + PW'(disp_accept_2);
      count    <= count_next;
      sq_full  <= (count_next == (PW+1)'(DEPTH));
      sq_empty <= (count_next == '0);
    end
  end
endmodule

// File: tb/tb_store_queue_param.sv
// Directed self-checking bench for store_queue_param (DEPTH=8).
// Inputs change 1ns after the rising edge; outputs are sampled before the
// next rising edge.
module tb_store_queue_param;
  localparam int DEPTH = 8, ADDR_W = 32, DATA_W = 32, ROB_W = 6, PW = 3;

  logic              clk = 0, reset = 1;
  logic              disp_valid_1, disp_valid_2;
  logic [ROB_W-1:0]  disp_rob_1, disp_rob_2;
  logic [DATA_W-1:0] disp_data_1, disp_data_2;
  logic [PW-1:0]     alloc_idx_1, alloc_idx_2;
  logic              disp_accept_1, disp_accept_2;
  logic              agu_valid_1, agu_valid_2;
  logic [PW-1:0]     agu_idx_1, agu_idx_2;
  logic [ADDR_W-1:0] agu_addr_1, agu_addr_2;
  logic              commit_valid, commit_ready;
  logic [ROB_W-1:0]  commit_rob;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              flush;
  logic [PW:0]       count;
  logic              sq_full, sq_empty;

  int n_chk = 0, n_pass = 0;

  store_queue_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset),
    .disp_valid_1(disp_valid_1), .disp_valid_2(disp_valid_2),
    .disp_rob_1(disp_rob_1), .disp_rob_2(disp_rob_2),
    .disp_data_1(disp_data_1), .disp_data_2(disp_data_2),
    .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .disp_accept_1(disp_accept_1), .disp_accept_2(disp_accept_2),
    .agu_valid_1(agu_valid_1), .agu_valid_2(agu_valid_2),
    .agu_idx_1(agu_idx_1), .agu_idx_2(agu_idx_2),
    .agu_addr_1(agu_addr_1), .agu_addr_2(agu_addr_2),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_rob(commit_rob),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .flush(flush), .count(count), .sq_full(sq_full), .sq_empty(sq_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_disp(input logic v1, input int r1, input int d1,
                          input logic v2, input int r2, input int d2);
    disp_valid_1 = v1; disp_rob_1 = ROB_W'(r1); disp_data_1 = DATA_W'(d1);
    disp_valid_2 = v2; disp_rob_2 = ROB_W'(r2); disp_data_2 = DATA_W'(d2);
  endtask

  task automatic set_agu(input logic v1, input int i1, input int a1,
                         input logic v2, input int i2, input int a2);
    agu_valid_1 = v1; agu_idx_1 = PW'(i1); agu_addr_1 = ADDR_W'(a1);
    agu_valid_2 = v2; agu_idx_2 = PW'(i2); agu_addr_2 = ADDR_W'(a2);
  endtask

  // first fill: entry i holds rob i+3, data D0+i, address 1000+4i
  function automatic int fa(input int i); return 32'h1000 + 4 * i; endfunction
  function automatic int fd(input int i); return 32'hD0 + i; endfunction

  initial begin
    set_disp(0, 0, 0, 0, 0, 0);
    set_agu(0, 0, 0, 0, 0, 0);
    commit_valid = 0; mem_req_ready = 0; flush = 0;
    tick(); tick();
    reset = 0; #1;

    // reset state
    chk("rst_count", count, 0);
    chk("rst_empty", sq_empty, 1);
    chk("rst_full", sq_full, 0);
    chk("rst_memv", mem_req_valid, 0);
    chk("rst_cready", commit_ready, 0);

    // first dual dispatch
    set_disp(1, 3, fd(0), 1, 4, fd(1)); #1;
    chk("d0_acc1", disp_accept_1, 1);
    chk("d0_acc2", disp_accept_2, 1);
    chk("d0_idx1", alloc_idx_1, 0);
    chk("d0_idx2", alloc_idx_2, 1);
    tick();
    set_disp(0, 0, 0, 0, 0, 0); #1;
    chk("d0_count", count, 2);
    chk("d0_empty", sq_empty, 0);

    // two more pairs, then a single, to reach count 7
    for (int p = 1; p < 3; p++) begin
      set_disp(1, 2*p+3, fd(2*p), 1, 2*p+4, fd(2*p+1)); #1;
      chk("fill_idx1", alloc_idx_1, 2*p);
      chk("fill_idx2", alloc_idx_2, 2*p+1);
      tick();
    end
    set_disp(1, 9, fd(6), 0, 0, 0);
    tick();
    set_disp(0, 0, 0, 0, 0, 0); #1;
    chk("c7_count", count, 7);

    // at count 7 only slot 1 fits
    set_disp(1, 10, fd(7), 1, 11, 32'hEE); #1;
    chk("c7_acc1", disp_accept_1, 1);
    chk("c7_idx1", alloc_idx_1, 7);
    chk("c7_acc2", disp_accept_2, 0);
    tick();
    set_disp(0, 0, 0, 0, 0, 0); #1;
    chk("full", sq_full, 1);
    chk("full_count", count, 8);
    set_disp(1, 12, 1, 1, 13, 2); #1;
    chk("full_acc1", disp_accept_1, 0);
    chk("full_acc2", disp_accept_2, 0);
    tick();
    set_disp(0, 0, 0, 0, 0, 0); #1;
    chk("full_hold", count, 8);

    // AGU idx1 first; a commit attempt while idx0 waits is ignored
    set_agu(1, 1, fa(1), 0, 0, 0);
    commit_valid = 1; #1;
    chk("cr_before", commit_ready, 0);
    tick();
    commit_valid = 0; #1;
    chk("cr_idx1only", commit_ready, 0);
    chk("crob_nomove", commit_rob, 3);
    set_agu(1, 0, fa(0), 1, 2, fa(2)); tick(); #1;
    chk("cr_idx0", commit_ready, 1);
    chk("crob_idx0", commit_rob, 3);
    set_agu(1, 3, fa(3), 1, 3, 32'hBAD); tick();   // same index: port 1 wins
    set_agu(1, 4, fa(4), 1, 5, fa(5)); tick();
    set_agu(1, 6, fa(6), 1, 7, fa(7)); tick();
    set_agu(1, 0, 32'hDEAD, 0, 0, 0); tick();      // idx0 READY: ignored
    set_agu(0, 0, 0, 0, 0, 0); #1;
    chk("memv_precommit", mem_req_valid, 0);

    // commit idx0, idx1
    commit_valid = 1; tick(); #1;
    chk("memv_c1", mem_req_valid, 1);
    chk("memaddr_c1", mem_req_addr, fa(0));
    chk("memdata_c1", mem_req_data, fd(0));
    chk("crob_c1", commit_rob, 4);
    tick();
    commit_valid = 0; #1;
    chk("crob_c2", commit_rob, 5);

    // memory stalls for 3 cycles: request holds
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_v", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, fa(0));
      chk("stall_data", mem_req_data, fd(0));
    end
    mem_req_ready = 1; tick();
    chk("pop0_addr", mem_req_addr, fa(1));
    chk("pop0_data", mem_req_data, fd(1));
    chk("pop0_count", count, 7);
    chk("pop0_full", sq_full, 0);
    tick();
    mem_req_ready = 0; #1;
    chk("pop1_count", count, 6);
    chk("pop1_memv", mem_req_valid, 0);

    // commit idx2..5, drain idx2..4 -> 1 COMMITTED + 2 READY remain
    commit_valid = 1;
    for (int c = 0; c < 4; c++) tick();
    commit_valid = 0; #1;
    chk("crob_c6", commit_rob, 9);
    mem_req_ready = 1;
    for (int j = 2; j < 5; j++) begin
      #1;
      chk("drain_addr", mem_req_addr, fa(j));
      chk("drain_data", mem_req_data, fd(j));
      tick();
    end
    mem_req_ready = 0; #1;
    chk("pre_flush_count", count, 3);

    // flush: dispatch blocked in the flush cycle
    flush = 1;
    set_disp(1, 20, 32'hE6, 0, 0, 0); #1;
    chk("flush_acc1", disp_accept_1, 0);
    tick();
    flush = 0; #1;
    chk("flush_count", count, 1);
    chk("flush_cready", commit_ready, 0);
    chk("flush_memv", mem_req_valid, 1);
    chk("flush_memaddr", mem_req_addr, fa(5));
    chk("flush_memdata", mem_req_data, fd(5));
    // new dispatch lands at old cptr (6) while the committed store drains
    mem_req_ready = 1; #1;
    chk("post_flush_acc", disp_accept_1, 1);
    chk("post_flush_idx", alloc_idx_1, 6);
    tick();
    set_disp(0, 0, 0, 0, 0, 0);
    mem_req_ready = 0; #1;
    chk("pf_count", count, 1);
    chk("pf_memv", mem_req_valid, 0);
    chk("pf_crob", commit_rob, 20);
    set_agu(1, 6, 32'h2000, 0, 0, 0); tick();
    set_agu(0, 0, 0, 0, 0, 0);
    commit_valid = 1; tick();
    commit_valid = 0; #1;
    chk("pf_memaddr", mem_req_addr, 32'h2000);
    chk("pf_memdata", mem_req_data, 32'hE6);
    mem_req_ready = 1; tick();
    mem_req_ready = 0; #1;
    chk("pf_empty_count", count, 0);
    chk("pf_empty", sq_empty, 1);

    // 20 stores across pointer wrap; head=cptr=tail=7 here
    for (int b = 0; b < 10; b++) begin
      int k0, k1;
      k0 = 2 * b; k1 = 2 * b + 1;
      set_disp(1, k0, 32'h100 + k0, 1, k1, 32'h100 + k1); #1;
      chk("wrap_idx1", alloc_idx_1, (7 + k0) % 8);
      chk("wrap_idx2", alloc_idx_2, (7 + k1) % 8);
      tick();
      set_disp(0, 0, 0, 0, 0, 0);
      set_agu(1, (7 + k0) % 8, 32'h3000 + 4 * k0, 1, (7 + k1) % 8, 32'h3000 + 4 * k1);
      tick();
      set_agu(0, 0, 0, 0, 0, 0);
      commit_valid = 1; tick(); tick();
      commit_valid = 0;
      mem_req_ready = 1;
      for (int k = k0; k <= k1; k++) begin
        #1;
        chk("wrap_addr", mem_req_addr, 32'h3000 + 4 * k);
        chk("wrap_data", mem_req_data, 32'h100 + k);
        tick();
      end
      mem_req_ready = 0;
    end
    #1;
    chk("end_count", count, 0);
    chk("end_empty", sq_empty, 1);
    chk("end_full", sq_full, 0);
    chk("end_memv", mem_req_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
